// File: rtl/mult_acc_array.sv
// Pipelined signed multiply-accumulate array: per-beat lane dot product, accumulated
// across a frame delimited by last_i, emitted as one saturated result per frame.
module mult_acc_array #(
    parameter int MULT_MODE      = 0,
    parameter int IN_DATA_WIDTH  = 8,
    parameter int NUM_LANES      = 4,
    parameter int ACC_WIDTH      = 32,
    parameter int OUT_DATA_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [NUM_LANES*IN_DATA_WIDTH-1:0]  a_i,
    input  logic [NUM_LANES*IN_DATA_WIDTH-1:0]  b_i,
    input  logic                                last_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [OUT_DATA_WIDTH-1:0]           p_o,
    output logic                                sat_o
);

    localparam int W  = IN_DATA_WIDTH;
    localparam int PW = 2 * IN_DATA_WIDTH;
    localparam int N  = NUM_LANES;
    localparam int AW = ACC_WIDTH;
    localparam int OW = OUT_DATA_WIDTH;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Input capture stage, registered on acceptance
    logic                  s0_valid_q, s0_last_q;
    logic [N*W-1:0]        s0_a_q, s0_b_q;

    logic                  s1_valid_q, s1_last_q;
    logic [N-1:0][W-1:0]   s1_mag_a_q, s1_mag_b_q, mag_a_d, mag_b_d;
    logic [N-1:0]          s1_sign_q, sign_d;

    logic                  s2_valid_q, s2_last_q;
    logic [N-1:0][PW-1:0]  s2_prod_q, prod_d;

    logic                  s3_valid_q, s3_last_q;
    logic signed [AW-1:0]  s3_sum_q, sum_d;

    logic signed [AW-1:0]  acc_q, final_d;
    logic                  first_q;
    logic                  valid_o_q, sat_q, clip_d, sat_hi, sat_lo;
    logic [OW-1:0]         p_q, p_d;
    logic                  advance;

    // One global stall: the whole pipe freezes while a result waits downstream.
    assign advance = ~(valid_o_q & ~ready_i);
    assign ready_o = advance & ~rst;

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [W-1:0]  a_k, b_k;
        logic [PW-1:0] prod_mag;

        assign a_k        = s0_a_q[k*W +: W];
        assign b_k        = s0_b_q[k*W +: W];
        // W-bit unsigned magnitude keeps the most-negative operand exact.
        assign mag_a_d[k] = a_k[W-1] ? -a_k : a_k;
        assign mag_b_d[k] = b_k[W-1] ? -b_k : b_k;
        assign sign_d[k]  = a_k[W-1] ^ b_k[W-1];

        if (MULT_MODE == 0) begin : g_shift_add
            always_comb begin
                prod_mag = '0;
                for (int i = 0; i < W; i++) begin
                    if (s1_mag_b_q[k][i]) begin
                        prod_mag = prod_mag + (PW'(s1_mag_a_q[k]) << i);
                    end
                end
            end
        end else begin : g_native
            assign prod_mag = PW'(s1_mag_a_q[k]) * PW'(s1_mag_b_q[k]);
        end

        assign prod_d[k] = s1_sign_q[k] ? -prod_mag : prod_mag;
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N; k++) begin
            sum_d = sum_d + AW'($signed(s2_prod_q[k]));
        end
    end

    always_comb begin
        final_d = first_q ? s3_sum_q : (acc_q + s3_sum_q);
        sat_hi  = (final_d > SAT_MAX);
        sat_lo  = (final_d < SAT_MIN);
        clip_d  = sat_hi | sat_lo;
        if (sat_hi) begin
            p_d = SAT_MAX[OW-1:0];
        end else if (sat_lo) begin
            p_d = SAT_MIN[OW-1:0];
        end else begin
            p_d = final_d[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_a_q     <= '0;
            s0_b_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mag_a_q <= '0;
            s1_mag_b_q <= '0;
            s1_sign_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            s3_sum_q   <= '0;
            acc_q      <= '0;
            first_q    <= 1'b1;
            valid_o_q  <= 1'b0;
            p_q        <= '0;
            sat_q      <= 1'b0;
        end else if (advance) begin
            s0_valid_q <= valid_i;
            s0_last_q  <= valid_i & last_i;
            s0_a_q     <= a_i;
            s0_b_q     <= b_i;

            s1_valid_q <= s0_valid_q;
            s1_last_q  <= s0_last_q;
            s1_mag_a_q <= mag_a_d;
            s1_mag_b_q <= mag_b_d;
            s1_sign_q  <= sign_d;

            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_prod_q  <= prod_d;

            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
            s3_sum_q   <= sum_d;

            valid_o_q  <= s3_valid_q & s3_last_q;
            // Bubbles leave acc and first untouched; overflow wraps silently.
            if (s3_valid_q) begin
                acc_q   <= final_d;
                first_q <= s3_last_q;
                if (s3_last_q) begin
                    p_q   <= p_d;
                    sat_q <= clip_d;
                end
            end
        end
    end

    assign valid_o = valid_o_q;
    assign p_o     = p_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_mult_acc_array.sv
// Directed bench for mult_acc_array: both multiplier styles driven in lockstep,
// results scoreboarded in order against hand-computed frame values.
module tb_mult_acc_array;

    logic               clk = 1'b0;
    logic               rst, valid_i, last_i, ready_i;
    logic [31:0]        a_i, b_i;
    logic               ready_o0, valid_o0, sat_o0;
    logic               ready_o1, valid_o1, sat_o1;
    logic signed [15:0] p_o0, p_o1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int accepted = 0;

    typedef struct {
        int p;
        bit s;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    mult_acc_array #(.MULT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o0),
        .a_i(a_i), .b_i(b_i), .last_i(last_i), .valid_o(valid_o0),
        .ready_i(ready_i), .p_o(p_o0), .sat_o(sat_o0)
    );

    mult_acc_array #(.MULT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o1),
        .a_i(a_i), .b_i(b_i), .last_i(last_i), .valid_o(valid_o1),
        .ready_i(ready_i), .p_o(p_o1), .sat_o(sat_o1)
    );

    task automatic check(input string tag, input longint got, input longint expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic push_exp(input int p, input bit s);
        exp_t x;
        x.p = p;
        x.s = s;
        exp_q.push_back(x);
    endtask

    // Presents a beat and holds it until it is accepted at a posedge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n;
        n = 0;
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        last_i  = last;
        @(negedge clk);
        while (!ready_o0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid_o0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, valid_o0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid_i && ready_o0) accepted <= accepted + 1;
    end

    // Scoreboard: every completed output handshake must match the next expected frame.
    always @(negedge clk) begin
        if (!rst && valid_o0 && ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("p_o", p_o0, e.p);
                check("sat_o", sat_o0, e.s);
                check("mode1_p_o", p_o1, p_o0);
                check("mode1_sat_o", sat_o1, sat_o0);
                check("mode1_valid_o", valid_o1, valid_o0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_cyc;
        int snap;

        rst = 1'b1; valid_i = 1'b0; last_i = 1'b0; a_i = '0; b_i = '0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_o", ready_o0, 0);
        check("rst_valid_o", valid_o0, 0);
        check("rst_p_o", p_o0, 0);
        check("rst_sat_o", sat_o0, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready_o0, 1);
        @(posedge clk); #1;

        // Single beat, latency
        push_exp(70, 0);
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1);
        acc_cyc = cyc;
        wait_valid("latency_valid");
        check("latency", cyc - acc_cyc, 4);
        drain();

        // Corner products, back-to-back one-beat frames
        push_exp(16384, 0);
        send(pk(-128, 0, 0, 0), pk(-128, 0, 0, 0), 1);
        push_exp(-16256, 0);
        send(pk(-128, 0, 0, 0), pk(127, 0, 0, 0), 1);
        push_exp(0, 0);
        send(pk(0, 0, 0, 0), pk(-1, 0, 0, 0), 1);
        push_exp(114, 0);
        send(pk(-128, 127, -1, 5), pk(-128, -128, -1, -3), 1);
        drain();

        // Three-beat frame with bubbles, then a one-beat frame
        push_exp(50, 0);
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 0);
        repeat (2) @(posedge clk);
        #1;
        send(pk(-1, -2, -3, 0), pk(5, 5, 5, 5), 0);
        send(pk(1, 1, 1, 1), pk(1, 2, 3, 4), 1);
        push_exp(5, 0);
        send(pk(5, 0, 0, 0), pk(1, 0, 0, 0), 1);
        drain();

        // Saturation and the exact boundaries
        push_exp(32767, 1);
        repeat (3) send(pk(127, 127, 127, 127), pk(127, 127, 127, 127), 0);
        send(pk(127, 127, 127, 127), pk(127, 127, 127, 127), 1);
        push_exp(-32768, 1);
        repeat (3) send(pk(127, 127, 127, 127), pk(-128, -128, -128, -128), 0);
        send(pk(127, 127, 127, 127), pk(-128, -128, -128, -128), 1);
        push_exp(32767, 0);
        send(pk(127, 127, 0, 0), pk(127, 127, 0, 0), 0);
        send(pk(127, 1, 0, 0), pk(4, 1, 0, 0), 1);
        push_exp(32767, 1);
        send(pk(127, 127, 0, 0), pk(127, 127, 0, 0), 0);
        send(pk(127, 1, 0, 0), pk(4, 2, 0, 0), 1);
        push_exp(-32768, 0);
        send(pk(-128, -128, 0, 0), pk(127, 127, 0, 0), 0);
        send(pk(-128, 0, 0, 0), pk(2, 0, 0, 0), 1);
        drain();

        // Backpressure with frames queued behind the held result
        ready_i = 1'b0;
        push_exp(70, 0);
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1);
        fork
            begin
                push_exp(10, 0);
                send(pk(1, 1, 1, 1), pk(1, 2, 3, 4), 1);
                push_exp(5, 0);
                send(pk(5, 0, 0, 0), pk(1, 0, 0, 0), 1);
                push_exp(-30, 0);
                send(pk(-1, -2, -3, 0), pk(5, 5, 5, 5), 1);
                push_exp(70, 0);
                send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1);
                push_exp(9, 0);
                send(pk(3, 0, 0, 0), pk(3, 0, 0, 0), 1);
                push_exp(1, 0);
                send(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1);
            end
            begin
                wait_valid("bp_valid");
                snap = accepted;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_p_hold", p_o0, 70);
                    check("bp_ready_low", ready_o0, 0);
                    check("bp_valid_hold", valid_o0, 1);
                end
                check("bp_no_accept", accepted, snap);
                @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        drain();

        // Reset drops a held result
        ready_i = 1'b0;
        send(pk(3, 0, 0, 0), pk(3, 0, 0, 0), 1);
        @(negedge clk);
        wait_valid("held_valid");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready_low", ready_o0, 0);
        @(negedge clk);
        check("rst_drop_valid", valid_o0, 0);
        check("rst_drop_p", p_o0, 0);
        @(posedge clk); #1 rst = 1'b0; ready_i = 1'b1;

        // Reset mid-frame discards the partial accumulation
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 0);
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push_exp(9, 0);
        send(pk(3, 0, 0, 0), pk(3, 0, 0, 0), 1);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_acc_array.md
# mult_acc_array

Parametrised, pipelined signed multiply-accumulate array. It takes NUM_LANES pairs of signed operands per beat, forms all lane products, reduces them to one lane sum per beat, and accumulates lane sums across a frame of beats delimited by `last_i`. At end of frame it emits one saturated result. It is the generalised successor of the 8-bit scalar multiplier and is the dot-product engine for attention-coefficient and feature-aggregation datapaths.

## Interface
- MULT_MODE, 0: lane multiplier style. 0 = sign-magnitude shift-add; 1 = native signed `*`. Both must be bit-identical.
- IN_DATA_WIDTH, 8: signed operand width per lane (≥2).
- NUM_LANES, 4: lanes per beat (≥1, any integer).
- ACC_WIDTH, 32: accumulator width. Must be ≥ 2·IN_DATA_WIDTH + clog2(NUM_LANES).
- OUT_DATA_WIDTH, 16: result width (≤ ACC_WIDTH).
- clk, input, 1: single clock, all logic on posedge.
- rst, input, 1: synchronous reset, active-high.
- valid_i, input, 1: input beat valid.
- ready_o, output, 1: input beat accepted when valid_i & ready_o.
- a_i, input, NUM_LANES·IN_DATA_WIDTH: packed signed operands; lane k = a_i[k·W +: W].
- b_i, input, NUM_LANES·IN_DATA_WIDTH: packed signed operands, same packing.
- last_i, input, 1: beat is final beat of its frame.
- valid_o, output, 1: result valid.
- ready_i, input, 1: downstream accepts result when valid_o & ready_i.
- p_o, output, OUT_DATA_WIDTH: signed saturated frame result.
- sat_o, output, 1: p_o was clipped; qualified by valid_o.

## Operation
- Pipeline: S1 registers per-lane |a|, |b|, sign = a[msb]^b[msb], plus last. S2 registers signed lane products, 2·IN_DATA_WIDTH bits each. S3 registers the sign-extended lane sum, ACC_WIDTH bits. S4 updates the accumulator and output registers.
- Magnitude is IN_DATA_WIDTH-bit unsigned, so the most-negative input is exact: −128 → 128 for W=8. (−128)·(−128) = +16384 must be exact.
- Mode 0 uses shift-add over all W magnitude bits, including the msb of the magnitude, then two's-complement negation when sign=1.
- Frame state: a `first` flag, set by reset and after each last beat.
  - A valid S3 beat with first=1 loads acc ← sum.
  - Otherwise acc ← acc + sum, wrapping modulo 2^ACC_WIDTH. Accumulator overflow is undetected by design.
- On a valid S3 beat with last=1:
  - Final = (first ? sum : acc + sum).
  - p_o ← saturate(final): clamp to [−2^(O−1), 2^(O−1)−1].
  - sat_o ← clipped flag; valid_o ← 1; first ← 1.
- A single-beat frame (last_i on its only beat) is legal: result = that beat's lane sum.
- Non-last beats never raise valid_o.

## Timing
- Reset values: ready_o=0 while rst=1. valid_o=0, p_o=0, sat_o=0, all stage valids=0, acc=0, first=1.
- ready_o=1 in the first cycle after rst deasserts.
- Global stall: advance = ~(valid_o & ~ready_i); ready_o = advance.
  - While stalled, all stage registers, the accumulator, p_o and sat_o hold.
  - Input is not accepted during a stall.
- Latency: a last beat accepted at edge t gives valid_o=1 after edge t+4, with no stall in between. Each stall cycle adds one.
- valid_o clears on the edge where valid_o & ready_i, unless a new result is produced that same edge. Back-to-back one-beat frames give one result per cycle when ready_i=1.
- Throughput: one beat per cycle when not stalled. Bubbles (valid_i=0) pass through without altering acc or first.
- rst mid-frame discards all in-flight beats and any partial accumulation. A held result is dropped: valid_o=0 on the next cycle.
- valid_i with ready_o=0 is ignored. The source must hold the beat.

## Test plan
- Single beat, NUM_LANES=4, W=8: a=(1,2,3,4), b=(5,6,7,8), last=1 → p_o=70, sat_o=0, valid_o exactly 4 cycles after acceptance.
- Corner products, 1-lane frame: (−128)·(−128) → 16384; (−128)·127 → −16256; 0·(−1) → 0. Run in MULT_MODE 0 and 1, outputs compared equal.
- Three-beat frame: lane sums 70, −30, 10, last on beat 3 → single result 50. No valid_o on beats 1–2. A following single-beat frame of sum 5 → 5, confirming first-flag restart.
- Saturation, OUT_DATA_WIDTH=16: four beats of all lanes 127·127 (sum 64516 each) → p_o=32767, sat_o=1. Negative mirror: 127·(−128) beats → p_o=−32768, sat_o=1.
- Backpressure: hold ready_i=0 for 5 cycles with a result pending. Expect p_o stable, ready_o=0, and no beats accepted. Release ready_i=1 → queued frames resume, results in order, none lost or duplicated.
- Reset mid-frame: accept 2 beats without last, pulse rst, then send a one-beat frame of sum 9 → p_o=9. The discarded beats must not contribute.
